// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData
    } state_e;

    // Value of the leading frame bit that marks a write
    localparam logic RW_WRITE = 1'b1;

    // Bits in one complete frame: R/W flag, address, data
    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with a configurable reset value and edge pulses.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the async input through the chain; keep last level for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI register-file peripheral: R/W register bank with read-back and frame checking.
module spi_regfile_peripheral
    import spi_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 8,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spi_sclk,
    input  logic                       spi_copi,
    input  logic                       spi_nCS,
    output logic                       spi_cipo,
    output logic                       spi_cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CMD_W   = 1 + ADDR_W;
    localparam int unsigned SHIFT_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_CMD_LAST = CNT_W'(CMD_W - 1);
    localparam bit               SAMPLE_RISE  = (CPOL == CPHA);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic unused_copi_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .d     (spi_sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk   (clk),
        .rst   (rst),
        .d     (spi_nCS),
        .level (ncs_lvl),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk   (clk),
        .rst   (rst),
        .d     (spi_copi),
        .level (copi_lvl),
        .rise  (copi_rise),
        .fall  (copi_fall)
    );

    assign unused_copi_edges = copi_rise ^ copi_fall ^ sclk_lvl;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [SHIFT_W-1:0]   shift_q;
    logic [SHIFT_W-1:0]   shift_next;
    logic                 rw_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [SYNC_STAGES-1:0] settle_q;
    logic                 armed_q;
    logic                 sample, launch;
    logic                 addr_in_range;
    logic [DATA_W-1:0]    rd_data;

    assign sample        = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign launch        = SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign shift_next    = {shift_q[SHIFT_W-2:0], copi_lvl};
    assign addr_in_range = 32'(addr_q) < NUM_REGS;

    // Read-back mux on the address being latched; out-of-range reads return zero
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_next[ADDR_W-1:0] == ADDR_W'(i)) begin
                rd_data = regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Frame FSM, bit counter, shifter, register bank and CIPO driver
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
            regs_flat   <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            frame_err   <= 1'b0;
            spi_cipo    <= 1'b0;
            spi_cipo_oe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            settle_q  <= {settle_q[SYNC_STAGES-2:0], 1'b1};
            // Only arm once the synchroniser holds real pin state and nCS was seen high,
            // so a select already active at reset release is not taken as a frame start.
            if (settle_q[SYNC_STAGES-1] && ncs_lvl) begin
                armed_q <= 1'b1;
            end

            if (ncs_rise) begin
                // Deselect has priority over any coincident SCLK edge
                state_q     <= StIdle;
                spi_cipo    <= 1'b0;
                spi_cipo_oe <= 1'b0;
                if (state_q != StIdle) begin
                    if (cnt_q == CNT_FULL) begin
                        if (rw_q == RW_WRITE && addr_in_range) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr_q == ADDR_W'(i)) begin
                                    regs_flat[i*DATA_W +: DATA_W] <= shift_q[DATA_W-1:0];
                                end
                            end
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr_q;
                        end
                    end else if (cnt_q != '0) begin
                        frame_err <= 1'b1;
                    end
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (ncs_fall && armed_q) begin
                            state_q <= StCmd;
                            cnt_q   <= '0;
                        end
                    end
                    StCmd: begin
                        if (sample) begin
                            shift_q <= shift_next;
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_CMD_LAST) begin
                                state_q <= StData;
                                rw_q    <= shift_next[ADDR_W];
                                addr_q  <= shift_next[ADDR_W-1:0];
                                if (shift_next[ADDR_W] != RW_WRITE) begin
                                    shift_q     <= SHIFT_W'(rd_data);
                                    spi_cipo_oe <= 1'b1;
                                end
                            end
                        end
                    end
                    StData: begin
                        if (sample) begin
                            if (cnt_q != CNT_MAX) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                            if (rw_q == RW_WRITE) begin
                                shift_q <= shift_next;
                            end
                        end else if (launch && rw_q != RW_WRITE) begin
                            spi_cipo <= shift_q[DATA_W-1];
                            shift_q  <= shift_q << 1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
